// File: rtl/ex_mem_pkg.sv
// Shared EX/MEM definitions: halt FSM encodings, memory access selector codes
// and helpers that fold unused selector codes back to a full-word access.
package ex_mem_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [1:0] WR_SRC_WORD  = 2'd0;
    localparam logic [1:0] WR_SRC_HALF  = 2'd1;
    localparam logic [1:0] WR_SRC_BYTE  = 2'd2;

    localparam logic [2:0] RD_SRC_WORD  = 3'd0;
    localparam logic [2:0] RD_SRC_SHALF = 3'd1;
    localparam logic [2:0] RD_SRC_SBYTE = 3'd2;
    localparam logic [2:0] RD_SRC_UHALF = 3'd3;
    localparam logic [2:0] RD_SRC_UBYTE = 3'd4;

    function automatic logic [1:0] legal_wr_src(input logic [1:0] sel);
        return (sel > WR_SRC_BYTE) ? WR_SRC_WORD : sel;
    endfunction

    function automatic logic [2:0] legal_rd_src(input logic [2:0] sel);
        return (sel > RD_SRC_UBYTE) ? RD_SRC_WORD : sel;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_reg.sv
// Pipeline register: one cycle, clear beats enable; holding is driven by
// the enable input (deasserted enable = stall).
module pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline boundary with halt drain FSM and retired counter; 1-cycle
// latency; i_stall holds every register, i_flush loads a bubble.
module ex_mem
    import ex_mem_pkg::*;
#(
    parameter int IO_BUS_SIZE   = 32,
    parameter int REG_ADDR_SIZE = 5,
    parameter int CNT_SIZE      = 32
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_stall,
    input  logic                     i_flush,
    input  logic                     i_valid,
    input  logic [IO_BUS_SIZE-1:0]   i_alu_res,
    input  logic [IO_BUS_SIZE-1:0]   i_bus_b,
    input  logic [REG_ADDR_SIZE-1:0] i_rd,
    input  logic                     i_mem_wr_rd,
    input  logic [1:0]               i_mem_wr_src,
    input  logic [2:0]               i_mem_rd_src,
    input  logic                     i_reg_wr,
    input  logic                     i_mem_to_reg,
    input  logic                     i_halt,
    output logic                     o_valid,
    output logic [IO_BUS_SIZE-1:0]   o_alu_res,
    output logic [IO_BUS_SIZE-1:0]   o_bus_b,
    output logic [REG_ADDR_SIZE-1:0] o_rd,
    output logic                     o_mem_wr_rd,
    output logic [1:0]               o_mem_wr_src,
    output logic [2:0]               o_mem_rd_src,
    output logic                     o_reg_wr,
    output logic                     o_mem_to_reg,
    output logic                     o_fwd_en,
    output logic                     o_halted,
    output logic [CNT_SIZE-1:0]      o_instr_count
);

    localparam int W = 2 * IO_BUS_SIZE + REG_ADDR_SIZE + 9;

    state_t              state;
    logic                halted_q;
    logic [CNT_SIZE-1:0] cnt_q;

    logic         running;
    logic         load_ok;
    logic         side_fx_ok;
    logic         stage_clr;
    logic [W-1:0] stage_d;
    logic [W-1:0] stage_q;

    assign running    = (state == ST_RUN);
    assign load_ok    = running & i_valid;
    // A halt occupies a real slot but must never store or write back.
    assign side_fx_ok = load_ok & ~i_halt;
    // Outside RUN every non-stalled load is replaced by a bubble.
    assign stage_clr  = i_flush | (~i_stall & ~running);

    assign stage_d = {load_ok,
                      i_alu_res,
                      i_bus_b,
                      i_rd,
                      i_mem_wr_rd & side_fx_ok,
                      legal_wr_src(i_mem_wr_src),
                      legal_rd_src(i_mem_rd_src),
                      i_reg_wr & side_fx_ok,
                      i_mem_to_reg};

    pipe_reg #(
        .WIDTH (W)
    ) u_stage (
        .clk (i_clk),
        .rst (i_reset),
        .en  (~i_stall),
        .clr (stage_clr),
        .d   (stage_d),
        .q   (stage_q)
    );

    assign {o_valid, o_alu_res, o_bus_b, o_rd, o_mem_wr_rd,
            o_mem_wr_src, o_mem_rd_src, o_reg_wr, o_mem_to_reg} = stage_q;

    assign o_fwd_en      = o_valid & o_reg_wr & (o_rd != '0);
    assign o_halted      = halted_q;
    assign o_instr_count = cnt_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_RUN;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else if (i_flush) begin
            // A flushed slot is squashed, but an in-progress drain still completes.
            if (state == ST_DRAIN) begin
                state    <= ST_HALTED;
                halted_q <= 1'b1;
            end
        end else if (!i_stall) begin
            if (load_ok) begin
                cnt_q <= cnt_q + CNT_SIZE'(1);
            end
            case (state)
                ST_RUN: begin
                    if (load_ok && i_halt) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state    <= ST_HALTED;
                    halted_q <= 1'b1;
                end
                default: begin
                    state    <= ST_HALTED;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: load, stall/flush, bubble masking, halt drain,
// async reset and counter wrap (4-bit counter).
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, valid;
    logic [31:0] alu_res, bus_b;
    logic [4:0]  rd;
    logic        mem_wr_rd;
    logic [1:0]  mem_wr_src;
    logic [2:0]  mem_rd_src;
    logic        reg_wr, mem_to_reg, halt;

    logic        o_valid;
    logic [31:0] o_alu_res, o_bus_b;
    logic [4:0]  o_rd;
    logic        o_mem_wr_rd;
    logic [1:0]  o_mem_wr_src;
    logic [2:0]  o_mem_rd_src;
    logic        o_reg_wr, o_mem_to_reg, o_fwd_en, o_halted;
    logic [3:0]  o_instr_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ex_mem #(
        .IO_BUS_SIZE   (32),
        .REG_ADDR_SIZE (5),
        .CNT_SIZE      (4)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_valid       (valid),
        .i_alu_res     (alu_res),
        .i_bus_b       (bus_b),
        .i_rd          (rd),
        .i_mem_wr_rd   (mem_wr_rd),
        .i_mem_wr_src  (mem_wr_src),
        .i_mem_rd_src  (mem_rd_src),
        .i_reg_wr      (reg_wr),
        .i_mem_to_reg  (mem_to_reg),
        .i_halt        (halt),
        .o_valid       (o_valid),
        .o_alu_res     (o_alu_res),
        .o_bus_b       (o_bus_b),
        .o_rd          (o_rd),
        .o_mem_wr_rd   (o_mem_wr_rd),
        .o_mem_wr_src  (o_mem_wr_src),
        .o_mem_rd_src  (o_mem_rd_src),
        .o_reg_wr      (o_reg_wr),
        .o_mem_to_reg  (o_mem_to_reg),
        .o_fwd_en      (o_fwd_en),
        .o_halted      (o_halted),
        .o_instr_count (o_instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic wr, input logic [1:0] ws,
                         input logic [2:0] rs, input logic rw, input logic m2r,
                         input logic h);
        valid      = v;
        alu_res    = a;
        bus_b      = b;
        rd         = r;
        mem_wr_rd  = wr;
        mem_wr_src = ws;
        mem_rd_src = rs;
        reg_wr     = rw;
        mem_to_reg = m2r;
        halt       = h;
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);

        #2;
        chk("rst_valid",  32'(o_valid), 32'd0);
        chk("rst_alu",    o_alu_res, 32'd0);
        chk("rst_count",  32'(o_instr_count), 32'd0);
        chk("rst_halted", 32'(o_halted), 32'd0);
        #6;
        rst = 1'b0;

        // Basic store load
        drive(1'b1, 32'h10, 32'hDEADBEEF, 5'd3, 1'b1, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("ld_valid",  32'(o_valid), 32'd1);
        chk("ld_alu",    o_alu_res, 32'h10);
        chk("ld_busb",   o_bus_b, 32'hDEADBEEF);
        chk("ld_wr_rd",  32'(o_mem_wr_rd), 32'd1);
        chk("ld_wr_src", 32'(o_mem_wr_src), 32'd2);
        chk("ld_count",  32'(o_instr_count), 32'd1);
        chk("ld_fwd",    32'(o_fwd_en), 32'd0);

        // Register-writing load: forwarding enabled for rd != 0
        drive(1'b1, 32'h20, 32'h0, 5'd5, 1'b0, 2'd0, 3'd4, 1'b1, 1'b1, 1'b0);
        step();
        chk("rw_fwd",    32'(o_fwd_en), 32'd1);
        chk("rw_rd_src", 32'(o_mem_rd_src), 32'd4);
        chk("rw_m2r",    32'(o_mem_to_reg), 32'd1);
        chk("rw_count",  32'(o_instr_count), 32'd2);

        // rd = 0 never forwards
        drive(1'b1, 32'h30, 32'h0, 5'd0, 1'b0, 2'd1, 3'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk("r0_fwd",    32'(o_fwd_en), 32'd0);
        chk("r0_wr_src", 32'(o_mem_wr_src), 32'd1);
        chk("r0_count",  32'(o_instr_count), 32'd3);

        // Stall for three cycles with changing inputs
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 32'h5, 5'(i + 9), 1'b1, 2'd2, 3'd3, 1'b1, 1'b0, 1'b0);
            step();
        end
        chk("stl_alu",   o_alu_res, 32'h30);
        chk("stl_rd",    32'(o_rd), 32'd0);
        chk("stl_wr_rd", 32'(o_mem_wr_rd), 32'd0);
        chk("stl_count", 32'(o_instr_count), 32'd3);

        // Flush wins over stall
        flush = 1'b1;
        drive(1'b1, 32'h55, 32'h66, 5'd4, 1'b1, 2'd1, 3'd1, 1'b1, 1'b1, 1'b0);
        step();
        chk("fl_valid",  32'(o_valid), 32'd0);
        chk("fl_alu",    o_alu_res, 32'd0);
        chk("fl_reg_wr", 32'(o_reg_wr), 32'd0);
        chk("fl_count",  32'(o_instr_count), 32'd3);
        flush = 1'b0;
        stall = 1'b0;

        // Invalid slot: data captured, side effects masked, illegal selectors folded
        drive(1'b0, 32'h77, 32'h88, 5'd6, 1'b1, 2'd3, 3'd6, 1'b1, 1'b1, 1'b0);
        step();
        chk("inv_valid",   32'(o_valid), 32'd0);
        chk("inv_wr_rd",   32'(o_mem_wr_rd), 32'd0);
        chk("inv_reg_wr",  32'(o_reg_wr), 32'd0);
        chk("inv_rd_src",  32'(o_mem_rd_src), 32'd0);
        chk("inv_wr_src",  32'(o_mem_wr_src), 32'd0);
        chk("inv_alu",     o_alu_res, 32'h77);
        chk("inv_count",   32'(o_instr_count), 32'd3);

        // Halt: slot retires without side effects, then drain to HALTED
        drive(1'b1, 32'hAA, 32'h1, 5'd7, 1'b1, 2'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        step();
        chk("h_valid",  32'(o_valid), 32'd1);
        chk("h_reg_wr", 32'(o_reg_wr), 32'd0);
        chk("h_wr_rd",  32'(o_mem_wr_rd), 32'd0);
        chk("h_halted", 32'(o_halted), 32'd0);
        chk("h_count",  32'(o_instr_count), 32'd4);
        drive(1'b1, 32'hBB, 32'h2, 5'd8, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk("d_valid",  32'(o_valid), 32'd0);
        chk("d_halted", 32'(o_halted), 32'd1);
        chk("d_count",  32'(o_instr_count), 32'd4);
        drive(1'b1, 32'hCC, 32'h3, 5'd9, 1'b1, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk("hd_valid",  32'(o_valid), 32'd0);
        chk("hd_halted", 32'(o_halted), 32'd1);
        chk("hd_count",  32'(o_instr_count), 32'd4);

        // Async reset pulse between edges
        #2;
        rst = 1'b1;
        #1;
        chk("ar_halted", 32'(o_halted), 32'd0);
        chk("ar_count",  32'(o_instr_count), 32'd0);
        chk("ar_valid",  32'(o_valid), 32'd0);
        #1;
        rst = 1'b0;
        drive(1'b1, 32'h99, 32'h0, 5'd2, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk("pr_valid", 32'(o_valid), 32'd1);
        chk("pr_alu",   o_alu_res, 32'h99);
        chk("pr_fwd",   32'(o_fwd_en), 32'd1);
        chk("pr_count", 32'(o_instr_count), 32'd1);

        // Counter wrap on a 4-bit counter
        for (int i = 0; i < 14; i++) begin
            step();
        end
        chk("wr_count15", 32'(o_instr_count), 32'd15);
        step();
        chk("wr_count0",  32'(o_instr_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 Parameter IO_BUS_SIZE, default 32: data bus width (`DEFAULT_MEM_BUS_SIZE).
REQ-002 Parameter REG_ADDR_SIZE, default 5: register-file address width.
REQ-003 Parameter CNT_SIZE, default 32: retired-instruction counter width.
REQ-004 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_stall  in  1  hold all registered state.
REQ-007 i_flush  in  1  load a bubble.
REQ-008 i_valid  in  1  EX slot holds a real instruction.
REQ-009 i_alu_res, i_bus_b  in  IO_BUS_SIZE each  EX results.
REQ-010 i_rd  in  REG_ADDR_SIZE  destination register.
REQ-011 i_mem_wr_rd  in  1  1 = store, 0 = read.
REQ-012 i_mem_wr_src  in  2  0 word, 1 halfword, 2 byte.
REQ-013 i_mem_rd_src  in  3  0 word, 1 sext half, 2 sext byte, 3 uext half, 4 uext byte.
REQ-014 i_reg_wr, i_mem_to_reg, i_halt  in  1 each  WB controls, halt instruction.
REQ-015 o_* mirrors of REQ-008..014 (o_valid, o_alu_res, o_bus_b, o_rd, o_mem_wr_rd, o_mem_wr_src, o_mem_rd_src, o_reg_wr, o_mem_to_reg)  out  same widths  feed the MEM stage.
REQ-016 o_fwd_en  out  1  o_valid & o_reg_wr & (o_rd != 0).
REQ-017 o_halted  out  1  pipeline halted; o_instr_count  out  CNT_SIZE  retired count.

Function
REQ-018 Latency: exactly one cycle from EX inputs to o_* outputs.
REQ-019 Priority per edge: flush > stall > load.
REQ-020 Flush: o_valid, o_mem_wr_rd, o_reg_wr, o_mem_to_reg cleared; data/selector fields cleared to 0.
REQ-021 Stall without flush: every register, FSM state and counter hold.
REQ-022 Load with i_valid=0: data captured, but o_mem_wr_rd and o_reg_wr forced 0 (no spurious store/write).
REQ-023 Selector values 3 for wr_src or 5..7 for rd_src are captured as 0 (word).
REQ-024 FSM states RUN, DRAIN, HALTED; reset state RUN.
REQ-025 RUN -> DRAIN when loading a valid instruction with i_halt=1; halt slot itself has o_reg_wr and o_mem_wr_rd forced 0.
REQ-026 DRAIN -> HALTED on next non-stalled edge; in DRAIN, incoming instructions load as bubbles.
REQ-027 HALTED: absorbing until reset; all loads become bubbles; o_halted=1 only in HALTED.
REQ-028 Flush in DRAIN does not return to RUN.
REQ-029 o_instr_count increments on each non-stalled, non-flushed load with i_valid=1 in RUN (halt included), wraps modulo 2^CNT_SIZE.
REQ-030 o_fwd_en is combinational from registered outputs only.

Reset
REQ-031 Asynchronous assertion clears all outputs to 0, FSM to RUN, counter to 0, independent of i_clk.
REQ-032 Reset mid-DRAIN or HALTED returns to RUN; first edge after deassertion loads normally.

Structure
REQ-033 FSM state encodings and selector code constants (WR_SRC_*, RD_SRC_*) live in the shared header with mem.vh definitions.
REQ-034 One sub-module, pipe_reg (width-parameterised, enable + sync clear + async reset), holds the data fields; FSM and counter in ex_mem.

Verification
REQ-035 Load i_valid=1, alu_res=0x00000010, bus_b=0xDEADBEEF, wr_rd=1, wr_src=2 -> next cycle same on outputs, count=1.
REQ-036 Stall held 3 cycles with changing inputs -> outputs and count unchanged; flush+stall together -> bubble, o_valid=0.
REQ-037 i_valid=0, i_mem_wr_rd=1, i_reg_wr=1 -> o_mem_wr_rd=0, o_reg_wr=0; rd_src=6 -> o_mem_rd_src=0.
REQ-038 Halt instruction then 2 valid ones -> DRAIN, then HALTED, o_halted=1, count increments once, later instructions never raise o_valid.
REQ-039 Count preloaded near 2^CNT_SIZE-1 (CNT_SIZE=4, 15 loads then 1) -> wraps to 0.
REQ-040 Async reset pulse between edges while HALTED -> outputs 0 immediately, o_halted=0; next valid load passes.
